// File: rtl/fetch_4w.sv
// ---------------------------------------------------------------------------
// fetch_4w : 4-wide instruction fetch stage
//
// Keeps the fetch PC and issues one 16-byte-aligned request at a time to
// instruction memory. Each 128-bit response becomes a 4-lane bundle
// (instructions, per-lane valid mask, 28-bit block PC). Bundles go to decode
// over a valid/ready handshake. A back-end redirect retargets the PC and
// discards any stale response or bundle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid    back-end redirect request
//   redirect_pc[31:0] redirect target (bits 1:0 ignored)
//   imem_req          memory request valid (combinational from registers)
//   imem_addr[31:0]   request address, {fetch_pc[31:4], 4'b0}
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid       response data valid (in order, one per request)
//   imem_rdata[127:0] response, [127:96] = word at offset 0
//   out_valid         bundle valid to decode
//   next_ready        decode can accept the bundle
//   inst_4W[127:0]    bundle instructions, same lane layout as imem_rdata
//   inst_4W_valid[3:0] lane mask, bit3 = lane0 ... bit0 = lane3
//   inst_4W_pc[27:0]  bundle block PC, fetch_pc[31:4]
//
// state | meaning
// ------+------------------------------------------------------------
// REQ   | request to memory is presented, waiting for imem_ready
// WAIT  | one request outstanding, waiting for imem_rvalid
// HOLD  | response parked in the pending buffer, output register busy
// ---------------------------------------------------------------------------
module fetch_4w #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [127:0] imem_rdata,
  output logic         out_valid,
  input  logic         next_ready,
  output logic [127:0] inst_4W,
  output logic [3:0]   inst_4W_valid,
  output logic [27:0]  inst_4W_pc
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]   state;
  // Word-aligned fetch PC; bits 1:0 are always zero so they are not stored.
  logic [31:2]  fetch_pc;
  logic         drop;

  logic         pend_valid;
  logic [127:0] pend_inst;
  logic [3:0]   pend_mask;
  logic [27:0]  pend_pc;

  logic         req_fire;
  logic         out_fire;
  logic         out_free;
  logic [27:0]  next_block;
  logic [3:0]   lane_mask;
  logic         unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_req   = (state == S_REQ) && !rst;
  assign imem_addr  = {fetch_pc[31:4], 4'b0000};
  assign req_fire   = imem_req && imem_ready;
  assign out_fire   = out_valid && next_ready;
  assign out_free   = !out_valid || out_fire;
  // Sequential fetch always moves to the next 16-byte block; the 28-bit add
  // wraps 32'hFFFFFFF0 to 32'h00000000 naturally.
  assign next_block = fetch_pc[31:4] + 28'd1;

  // Lanes before the fetch PC's word offset are not part of the stream.
  always_comb begin
    lane_mask = 4'b1111;
    case (fetch_pc[3:2])
      2'd0:    lane_mask = 4'b1111;
      2'd1:    lane_mask = 4'b0111;
      2'd2:    lane_mask = 4'b0011;
      default: lane_mask = 4'b0001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_REQ;
      fetch_pc      <= RESET_PC[31:2];
      drop          <= 1'b0;
      pend_valid    <= 1'b0;
      pend_inst     <= '0;
      pend_mask     <= '0;
      pend_pc       <= '0;
      out_valid     <= 1'b0;
      inst_4W       <= '0;
      inst_4W_valid <= '0;
      inst_4W_pc    <= '0;
    end else begin
      // A consumed bundle empties the output register unless refilled below.
      if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (redirect_valid) begin
        // Any bundle firing this cycle has already been taken by decode;
        // everything still held here is on the wrong path.
        fetch_pc   <= redirect_pc[31:2];
        out_valid  <= 1'b0;
        pend_valid <= 1'b0;
        case (state)
          S_REQ: begin
            if (req_fire) begin
              // The request just issued belongs to the old path.
              state <= S_WAIT;
              drop  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end
          S_HOLD: begin
            state <= S_REQ;
          end
          default: begin
            state <= S_REQ;
          end
        endcase
      end else begin
        case (state)
          S_REQ: begin
            if (req_fire) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_REQ;
              end else if (out_free) begin
                inst_4W       <= imem_rdata;
                inst_4W_valid <= lane_mask;
                inst_4W_pc    <= fetch_pc[31:4];
                out_valid     <= 1'b1;
                fetch_pc      <= {next_block, 2'b00};
                state         <= S_REQ;
              end else begin
                // Decode is stalled: park the response and stop requesting
                // until the output register drains.
                pend_inst  <= imem_rdata;
                pend_mask  <= lane_mask;
                pend_pc    <= fetch_pc[31:4];
                pend_valid <= 1'b1;
                fetch_pc   <= {next_block, 2'b00};
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (out_free) begin
              inst_4W       <= pend_inst;
              inst_4W_valid <= pend_mask;
              inst_4W_pc    <= pend_pc;
              out_valid     <= 1'b1;
              pend_valid    <= 1'b0;
              state         <= S_REQ;
            end
          end
          default: begin
            state <= S_REQ;
          end
        endcase
      end
    end
  end

endmodule
